// File: rtl/ysyx_041461_clint_pkg.sv
// Shared definitions for the CLINT AXI4 responder: read/write FSM state
// encodings, AXI response codes, default register addresses and the
// byte-strobe merge helper used by the register write ports.
package ysyx_041461_clint_pkg;

    typedef enum logic {
        R_IDLE = 1'b0,
        R_DATA = 1'b1
    } r_state_t;

    typedef enum logic [1:0] {
        W_IDLE = 2'b00,
        W_DATA = 2'b01,
        W_RESP = 2'b10
    } w_state_t;

    typedef enum logic [1:0] {
        RESP_OKAY   = 2'b00,
        RESP_EXOKAY = 2'b01,
        RESP_SLVERR = 2'b10,
        RESP_DECERR = 2'b11
    } resp_t;

    localparam logic [31:0] CLINT_MTIME_ADDR    = 32'h0200_bff8;
    localparam logic [31:0] CLINT_MTIMECMP_ADDR = 32'h0200_4000;

    // Replace each byte of old_val whose strobe bit is set with the
    // corresponding byte of new_val.
    function automatic logic [63:0] strb_merge(input logic [63:0] old_val,
                                               input logic [63:0] new_val,
                                               input logic [7:0]  strb);
        logic [63:0] res;
        for (int i = 0; i < 8; i++) begin
            res[i*8 +: 8] = strb[i] ? new_val[i*8 +: 8] : old_val[i*8 +: 8];
        end
        return res;
    endfunction

endpackage

// File: rtl/ysyx_041461_clint_timer.sv
// CLINT timer core: free-running 64-bit mtime with prescaler, mtimecmp
// compare register and the registered machine timer interrupt.
// Ports:
//   clk, rst                 clock, async active-high reset
//   mtime_we, mtimecmp_we    byte-strobed write enables (one per register)
//   wdata, wstrb             write data and byte strobes
//   mtime, mtimecmp          current register values
//   timer_irq                registered (mtime >= mtimecmp)
module ysyx_041461_clint_timer
    import ysyx_041461_clint_pkg::*;
#(
    parameter int TICK_DIV = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mtime_we,
    input  logic        mtimecmp_we,
    input  logic [63:0] wdata,
    input  logic [7:0]  wstrb,
    output logic [63:0] mtime,
    output logic [63:0] mtimecmp,
    output logic        timer_irq
);

    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    logic [PW-1:0] presc;
    logic          tick;

    assign tick = (presc == PW'(TICK_DIV - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) presc <= '0;
        else     presc <= tick ? '0 : presc + PW'(1);
    end

    // A software write takes priority; a tick coinciding with it is dropped.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)           mtime <= 64'd0;
        else if (mtime_we) mtime <= strb_merge(mtime, wdata, wstrb);
        else if (tick)     mtime <= mtime + 64'd1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)              mtimecmp <= '1;
        else if (mtimecmp_we) mtimecmp <= strb_merge(mtimecmp, wdata, wstrb);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) timer_irq <= 1'b0;
        else     timer_irq <= (mtime >= mtimecmp);
    end

endmodule

// File: rtl/ysyx_041461_clint_axi_slave.sv
// AXI4 slave front end of the CLINT. Independent read and write FSMs decode
// addr[31:3] against mtime/mtimecmp; every beat of a burst targets the same
// register. Unmapped addresses answer DECERR (reads return 0, writes dropped).
// Ports:
//   clk, rst                              clock, async active-high reset
//   aw*/w*/b*                             AXI4 write address/data/response
//   ar*/r*                                AXI4 read address/data
//   timer_irq                             machine timer interrupt (level)
module ysyx_041461_clint_axi_slave
    import ysyx_041461_clint_pkg::*;
#(
    parameter logic [31:0] MTIME_ADDR    = CLINT_MTIME_ADDR,
    parameter logic [31:0] MTIMECMP_ADDR = CLINT_MTIMECMP_ADDR,
    parameter int          TICK_DIV      = 1
) (
    input  logic        clk,
    input  logic        rst,
    output logic        awready,
    input  logic        awvalid,
    input  logic [3:0]  awid,
    input  logic [31:0] awaddr,
    input  logic [7:0]  awlen,
    input  logic [2:0]  awsize,
    input  logic [1:0]  awburst,
    output logic        wready,
    input  logic        wvalid,
    input  logic [63:0] wdata,
    input  logic [7:0]  wstrb,
    input  logic        wlast,
    input  logic        bready,
    output logic        bvalid,
    output logic [3:0]  bid,
    output logic [1:0]  bresp,
    output logic        arready,
    input  logic        arvalid,
    input  logic [3:0]  arid,
    input  logic [31:0] araddr,
    input  logic [7:0]  arlen,
    input  logic [2:0]  arsize,
    input  logic [1:0]  arburst,
    input  logic        rready,
    output logic        rvalid,
    output logic [3:0]  rid,
    output logic [1:0]  rresp,
    output logic [63:0] rdata,
    output logic        rlast,
    output logic        timer_irq
);

    r_state_t    r_state, r_state_nx;
    w_state_t    w_state, w_state_nx;
    logic [7:0]  r_cnt;
    logic        r_sel_time, r_sel_cmp;
    logic        w_sel_time, w_sel_cmp;
    logic        ar_hit_time, ar_hit_cmp, aw_hit_time, aw_hit_cmp;
    logic        ar_hs, r_hs, aw_hs, w_hs;
    logic        mtime_we, mtimecmp_we;
    logic [63:0] mtime, mtimecmp;

    // Size, burst type, length of writes and byte offset play no part.
    logic unused_sig;
    assign unused_sig = ^{awlen, awsize, awburst, arsize, arburst,
                          awaddr[2:0], araddr[2:0]};

    assign ar_hit_time = (araddr[31:3] == MTIME_ADDR[31:3]);
    assign ar_hit_cmp  = (araddr[31:3] == MTIMECMP_ADDR[31:3]);
    assign aw_hit_time = (awaddr[31:3] == MTIME_ADDR[31:3]);
    assign aw_hit_cmp  = (awaddr[31:3] == MTIMECMP_ADDR[31:3]);

    assign arready = (r_state == R_IDLE);
    assign rvalid  = (r_state == R_DATA);
    assign rlast   = rvalid && (r_cnt == 8'd0);
    assign awready = (w_state == W_IDLE);
    assign wready  = (w_state == W_DATA);
    assign bvalid  = (w_state == W_RESP);

    assign ar_hs = arready && arvalid;
    assign r_hs  = rvalid && rready;
    assign aw_hs = awready && awvalid;
    assign w_hs  = wready && wvalid;

    // ---------------- read channel ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= R_IDLE;
        else     r_state <= r_state_nx;
    end

    always_comb begin
        r_state_nx = r_state;
        case (r_state)
            R_IDLE:  if (arvalid) r_state_nx = R_DATA;
            R_DATA:  if (rready && r_cnt == 8'd0) r_state_nx = R_IDLE;
            default: r_state_nx = R_IDLE;
        endcase
    end

    // rdata is sampled at the edge a beat is presented and then held, so it
    // stays stable across rready stalls.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt      <= 8'd0;
            rid        <= 4'd0;
            rresp      <= RESP_OKAY;
            rdata      <= 64'd0;
            r_sel_time <= 1'b0;
            r_sel_cmp  <= 1'b0;
        end else if (ar_hs) begin
            r_cnt      <= arlen;
            rid        <= arid;
            r_sel_time <= ar_hit_time;
            r_sel_cmp  <= ar_hit_cmp;
            rresp      <= (ar_hit_time || ar_hit_cmp) ? RESP_OKAY : RESP_DECERR;
            rdata      <= ar_hit_time ? mtime : (ar_hit_cmp ? mtimecmp : 64'd0);
        end else if (r_hs && r_cnt != 8'd0) begin
            r_cnt <= r_cnt - 8'd1;
            rdata <= r_sel_time ? mtime : (r_sel_cmp ? mtimecmp : 64'd0);
        end
    end

    // ---------------- write channel ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) w_state <= W_IDLE;
        else     w_state <= w_state_nx;
    end

    always_comb begin
        w_state_nx = w_state;
        case (w_state)
            W_IDLE:  if (awvalid) w_state_nx = W_DATA;
            W_DATA:  if (wvalid && wlast) w_state_nx = W_RESP;
            W_RESP:  if (bready) w_state_nx = W_IDLE;
            default: w_state_nx = W_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bid        <= 4'd0;
            bresp      <= RESP_OKAY;
            w_sel_time <= 1'b0;
            w_sel_cmp  <= 1'b0;
        end else if (aw_hs) begin
            bid        <= awid;
            w_sel_time <= aw_hit_time;
            w_sel_cmp  <= aw_hit_cmp;
            bresp      <= (aw_hit_time || aw_hit_cmp) ? RESP_OKAY : RESP_DECERR;
        end
    end

    assign mtime_we    = w_hs && w_sel_time;
    assign mtimecmp_we = w_hs && w_sel_cmp;

    ysyx_041461_clint_timer #(
        .TICK_DIV(TICK_DIV)
    ) u_timer (
        .clk        (clk),
        .rst        (rst),
        .mtime_we   (mtime_we),
        .mtimecmp_we(mtimecmp_we),
        .wdata      (wdata),
        .wstrb      (wstrb),
        .mtime      (mtime),
        .mtimecmp   (mtimecmp),
        .timer_irq  (timer_irq)
    );

endmodule

// File: tb/tb_ysyx_041461_clint_axi_slave.sv
// Self-checking bench for the CLINT AXI4 slave: a transaction-level model of
// the register file and channel occupancy is compared with the DUT every
// cycle, plus directed scenarios with hand-computed expectations, then a
// randomized phase.
module tb_ysyx_041461_clint_axi_slave;

    localparam logic [31:0] MTIME_A    = 32'h0200_bff8;
    localparam logic [31:0] MTIMECMP_A = 32'h0200_4000;
    localparam logic [31:0] BAD_A      = 32'h0200_0000;

    logic        clk, rst;
    logic        awready, awvalid;
    logic [3:0]  awid;
    logic [31:0] awaddr;
    logic [7:0]  awlen;
    logic [2:0]  awsize;
    logic [1:0]  awburst;
    logic        wready, wvalid, wlast;
    logic [63:0] wdata;
    logic [7:0]  wstrb;
    logic        bready, bvalid;
    logic [3:0]  bid;
    logic [1:0]  bresp;
    logic        arready, arvalid;
    logic [3:0]  arid;
    logic [31:0] araddr;
    logic [7:0]  arlen;
    logic [2:0]  arsize;
    logic [1:0]  arburst;
    logic        rready, rvalid, rlast;
    logic [3:0]  rid;
    logic [1:0]  rresp;
    logic [63:0] rdata;
    logic        timer_irq;

    int n_checks = 0;
    int n_err    = 0;

    ysyx_041461_clint_axi_slave dut (
        .clk(clk), .rst(rst),
        .awready(awready), .awvalid(awvalid), .awid(awid), .awaddr(awaddr),
        .awlen(awlen), .awsize(awsize), .awburst(awburst),
        .wready(wready), .wvalid(wvalid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast),
        .bready(bready), .bvalid(bvalid), .bid(bid), .bresp(bresp),
        .arready(arready), .arvalid(arvalid), .arid(arid), .araddr(araddr),
        .arlen(arlen), .arsize(arsize), .arburst(arburst),
        .rready(rready), .rvalid(rvalid), .rid(rid), .rresp(rresp),
        .rdata(rdata), .rlast(rlast), .timer_irq(timer_irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    function automatic logic [1:0] sel_of(input logic [31:0] a);
        if (a[31:3] == MTIME_A[31:3])    return 2'd1;
        if (a[31:3] == MTIMECMP_A[31:3]) return 2'd2;
        return 2'd0;
    endfunction

    function automatic logic [63:0] merge(input logic [63:0] o, input logic [63:0] n,
                                          input logic [7:0] s);
        logic [63:0] r;
        for (int i = 0; i < 8; i++) r[i*8 +: 8] = s[i] ? n[i*8 +: 8] : o[i*8 +: 8];
        return r;
    endfunction

    function automatic logic [63:0] val_of(input logic [1:0] s, input logic [63:0] t,
                                           input logic [63:0] c);
        return (s == 2'd1) ? t : ((s == 2'd2) ? c : 64'd0);
    endfunction

    logic [63:0] m_mtime = 64'd0, m_cmp = '1, m_rdata = 64'd0;
    bit          m_irq = 1'b0, m_rbusy = 1'b0;
    int          m_rleft = 0, m_wph = 0;   // write phase: 0 addr, 1 data, 2 resp
    logic [3:0]  m_rid = 4'd0, m_bid = 4'd0;
    logic [1:0]  m_rresp = 2'd0, m_bresp = 2'd0, m_rsel = 2'd0, m_wsel = 2'd0;

    always @(posedge clk or posedge rst) begin
        logic [63:0] t0, c0, t1, c1;
        if (rst) begin
            m_mtime = 64'd0; m_cmp = '1; m_irq = 1'b0; m_rbusy = 1'b0;
            m_rleft = 0; m_wph = 0; m_rdata = 64'd0;
        end else begin
            t0 = m_mtime; c0 = m_cmp;
            t1 = t0 + 64'd1; c1 = c0;
            if (!m_rbusy) begin
                if (arvalid) begin
                    m_rbusy = 1'b1; m_rleft = int'(arlen); m_rid = arid;
                    m_rsel = sel_of(araddr);
                    m_rresp = (m_rsel == 2'd0) ? 2'b11 : 2'b00;
                    m_rdata = val_of(m_rsel, t0, c0);
                end
            end else if (rready) begin
                if (m_rleft == 0) m_rbusy = 1'b0;
                else begin
                    m_rleft--;
                    m_rdata = val_of(m_rsel, t0, c0);
                end
            end
            if (m_wph == 0) begin
                if (awvalid) begin
                    m_wph = 1; m_bid = awid; m_wsel = sel_of(awaddr);
                    m_bresp = (m_wsel == 2'd0) ? 2'b11 : 2'b00;
                end
            end else if (m_wph == 1) begin
                if (wvalid) begin
                    if (m_wsel == 2'd1) t1 = merge(t0, wdata, wstrb);
                    else if (m_wsel == 2'd2) c1 = merge(c0, wdata, wstrb);
                    if (wlast) m_wph = 2;
                end
            end else if (bready) m_wph = 0;
            m_irq = (t0 >= c0);
            m_mtime = t1; m_cmp = c1;
        end
    end

    always @(negedge clk) begin
        #1;
        check("arready", arready, !m_rbusy);
        check("rvalid", rvalid, m_rbusy);
        check("rlast", rlast, m_rbusy && m_rleft == 0);
        if (m_rbusy) begin
            check("rid", rid, m_rid);
            check("rresp", rresp, m_rresp);
            check("rdata", rdata, m_rdata);
        end
        check("awready", awready, m_wph == 0);
        check("wready", wready, m_wph == 1);
        check("bvalid", bvalid, m_wph == 2);
        if (m_wph == 2) begin
            check("bid", bid, m_bid);
            check("bresp", bresp, m_bresp);
        end
        check("timer_irq", timer_irq, m_irq);
    end

    // ---------------- driver helpers (start and end just after a negedge) ----
    logic [63:0] rd_data [0:15];
    bit          rd_last [0:15];
    int          rd_n;
    logic [1:0]  rd_resp, wr_bresp;
    logic [3:0]  rd_id, wr_bid;
    int          wr_bwait;

    task automatic ar_wait();
        bit ok = 1'b0;
        for (int i = 0; i < 50 && !ok; i++) begin @(posedge clk); ok = arready; end
        check("ar_handshake", ok, 1);
    endtask

    task automatic aw_wait();
        bit ok = 1'b0;
        for (int i = 0; i < 50 && !ok; i++) begin @(posedge clk); ok = awready; end
        check("aw_handshake", ok, 1);
    endtask

    task automatic rd(input logic [31:0] a, input logic [7:0] len, input logic [3:0] id,
                      input bit toggle);
        bit done = 1'b0;
        arvalid = 1'b1; araddr = a; arlen = len; arid = id; rready = 1'b0;
        ar_wait();
        @(negedge clk);
        arvalid = 1'b0; rd_n = 0;
        for (int k = 0; k < 100 && !done; k++) begin
            rready = toggle ? (k % 2 == 0) : 1'b1;
            @(posedge clk);
            if (rvalid && rready && rd_n < 16) begin
                rd_data[rd_n] = rdata; rd_last[rd_n] = rlast;
                rd_resp = rresp; rd_id = rid; rd_n++; done = rlast;
            end
            @(negedge clk);
        end
        rready = 1'b0;
        check("r_complete", done, 1);
    endtask

    task automatic wr1(input logic [31:0] a, input logic [3:0] id, input logic [63:0] d,
                       input logic [7:0] s);
        bit ok = 1'b0;
        awvalid = 1'b1; awaddr = a; awid = id; awlen = 8'd0;
        aw_wait();
        @(negedge clk);
        awvalid = 1'b0; wvalid = 1'b1; wdata = d; wstrb = s; wlast = 1'b1;
        for (int i = 0; i < 50 && !ok; i++) begin @(posedge clk); ok = wready; end
        check("w_handshake", ok, 1);
        @(negedge clk);
        wvalid = 1'b0; wlast = 1'b0; bready = 1'b1; wr_bwait = 0; ok = 1'b0;
        for (int i = 0; i < 50 && !ok; i++) begin
            @(posedge clk); wr_bwait++; ok = bvalid;
            if (ok) begin wr_bid = bid; wr_bresp = bresp; end
        end
        check("b_handshake", ok, 1);
        @(negedge clk);
        bready = 1'b0;
    endtask

    function automatic logic [31:0] pick_addr();
        int r = int'($urandom_range(0, 3));
        case (r)
            0:       return {MTIME_A[31:3], 3'($urandom)};
            1:       return {MTIMECMP_A[31:3], 3'($urandom)};
            2:       return BAD_A;
            default: return $urandom;
        endcase
    endfunction

    // ---------------- main sequence ----------------
    initial begin
        logic [63:0] pre;
        rst = 1'b1;
        awvalid = 0; awid = 0; awaddr = 0; awlen = 0; awsize = 0; awburst = 0;
        wvalid = 0; wdata = 0; wstrb = 0; wlast = 0; bready = 0;
        arvalid = 0; arid = 0; araddr = 0; arlen = 0; arsize = 0; arburst = 0; rready = 0;

        repeat (3) @(negedge clk);
        #1;
        check("reset_arready", arready, 1);
        check("reset_awready", awready, 1);
        check("reset_irq", timer_irq, 0);
        check("reset_rvalid", rvalid, 0);
        check("reset_wready", wready, 0);
        check("reset_bvalid", bvalid, 0);
        @(negedge clk);
        rst = 1'b0;

        // AR handshake lands on the 10th edge after reset release
        repeat (9) @(negedge clk);
        rd(MTIME_A, 8'd0, 4'd0, 1'b0);
        check("mtime_cycle10", (rd_data[0] == 64'd9 || rd_data[0] == 64'd10), 1);
        check("mtime_cycle10_rid", rd_id, 0);
        check("mtime_cycle10_rresp", rd_resp, 2'b00);

        // mtimecmp = 100
        wr1(MTIMECMP_A, 4'd1, 64'd100, 8'hFF);
        check("cmp_wr_bid", wr_bid, 1);
        check("cmp_wr_bresp", wr_bresp, 2'b00);
        check("cmp_wr_blatency", wr_bwait, 1);
        #1 check("irq_before_100", timer_irq, 0);
        repeat (100) @(negedge clk);
        #1 check("irq_after_100", timer_irq, 1);

        // two-beat mtime write (low half then high half), then read 3 beats
        @(negedge clk);
        awvalid = 1'b1; awaddr = MTIME_A; awid = 4'd2;
        aw_wait();
        @(negedge clk);
        awvalid = 1'b0; wvalid = 1'b1; wdata = 64'hFFFF_FFFF_FFFF_FFFE; wstrb = 8'h0F; wlast = 1'b0;
        @(posedge clk);
        @(negedge clk);
        wstrb = 8'hF0; wlast = 1'b1;
        @(posedge clk);
        @(negedge clk);
        wvalid = 1'b0; wlast = 1'b0; bready = 1'b1;
        rd(MTIME_A, 8'd2, 4'd3, 1'b0);
        bready = 1'b0;
        check("wrap_beats", rd_n, 3);
        check("wrap_merged", rd_data[0], 64'hFFFF_FFFF_FFFF_FFFE);
        check("wrap_max", rd_data[1], 64'hFFFF_FFFF_FFFF_FFFF);
        check("wrap_zero", rd_data[2], 64'd0);

        // 4-beat burst of mtimecmp with rready toggling
        rd(MTIMECMP_A, 8'd3, 4'd9, 1'b1);
        check("burst_beats", rd_n, 4);
        check("burst_rlast_pattern", {rd_last[0], rd_last[1], rd_last[2], rd_last[3]}, 4'b0001);
        for (int i = 0; i < 4; i++) check("burst_data", rd_data[i], 64'd100);
        check("burst_rid", rd_id, 9);

        // unmapped address
        rd(BAD_A, 8'd0, 4'd7, 1'b0);
        check("decerr_rresp", rd_resp, 2'b11);
        check("decerr_rdata", rd_data[0], 64'd0);
        wr1(BAD_A, 4'd6, 64'h1234_5678_9ABC_DEF0, 8'hFF);
        check("decerr_bresp", wr_bresp, 2'b11);
        check("decerr_bid", wr_bid, 6);
        rd(MTIMECMP_A, 8'd0, 4'd0, 1'b0);
        check("decerr_cmp_unchanged", rd_data[0], 64'd100);

        // concurrent mtime read and mtime=5 write on the same edge
        awvalid = 1'b1; awaddr = MTIME_A; awid = 4'd4;
        aw_wait();
        @(negedge clk);
        awvalid = 1'b0; wvalid = 1'b1; wdata = 64'd5; wstrb = 8'hFF; wlast = 1'b1;
        arvalid = 1'b1; araddr = MTIME_A; arlen = 8'd0; arid = 4'd5; rready = 1'b1; bready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        wvalid = 1'b0; wlast = 1'b0; arvalid = 1'b0;
        @(posedge clk);
        pre = rdata;
        @(negedge clk);
        rready = 1'b0; bready = 1'b0;
        check("concurrent_pre_write", (pre != 64'd5), 1);
        rd(MTIME_A, 8'd0, 4'd0, 1'b0);
        check("after_write_mtime", rd_data[0], 64'd6);

        // reset during the write data phase
        awvalid = 1'b1; awaddr = MTIMECMP_A; awid = 4'd8;
        aw_wait();
        @(negedge clk);
        awvalid = 1'b0; rst = 1'b1;
        #1;
        check("rst_wready", wready, 0);
        check("rst_awready", awready, 1);
        check("rst_arready", arready, 1);
        check("rst_bvalid", bvalid, 0);
        check("rst_rdata", rdata, 64'd0);
        check("rst_bid", bid, 0);
        check("rst_rid", rid, 0);
        @(negedge clk);
        rst = 1'b0;

        // randomized traffic
        for (int i = 0; i < 4000; i++) begin
            @(negedge clk);
            rst = (i >= 2000 && i < 2002);
            arvalid = ($urandom_range(0, 3) == 0);
            araddr = pick_addr(); arlen = 8'($urandom_range(0, 3)); arid = 4'($urandom);
            arsize = 3'($urandom); arburst = 2'($urandom);
            rready = ($urandom_range(0, 2) != 0);
            awvalid = ($urandom_range(0, 3) == 0);
            awaddr = pick_addr(); awlen = 8'($urandom); awid = 4'($urandom);
            awsize = 3'($urandom); awburst = 2'($urandom);
            wvalid = 1'($urandom);
            wdata = ($urandom_range(0, 1) == 1) ? {32'd0, 32'($urandom_range(0, 3000))}
                                                : {$urandom, $urandom};
            wstrb = ($urandom_range(0, 1) == 1) ? 8'hFF : 8'($urandom);
            wlast = ($urandom_range(0, 2) == 0);
            bready = 1'($urandom);
        end
        @(negedge clk);
        rst = 1'b0; arvalid = 0; awvalid = 0; wvalid = 0; rready = 1; bready = 1;
        repeat (10) @(negedge clk);
        #2;
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
